ami_client_mux: RTL and testbench
=================================

# ami_client_mux

Parametrised N-client front end for the AMI memory ports. It merges `NUM_CLIENTS` independent AMIRequest/AMIResponse channels onto AMI port 0 (reads) and port 1 (writes). Arbitration is round-robin with a per-port lock. Read responses are routed in order via an ID FIFO. It sits between several accelerator/BlockBuffer instances and `mem_req`/`mem_resp`, generalising the single-client top-level wiring to multiple accelerator instances sharing one memory interface.

## Interface
- `NUM_CLIENTS`, default 4: number of client channels, ≥1.
- `MAX_OUTSTANDING`, default 16: read ID FIFO depth, power of two, ≥2.
- `CLIENT_ID_W`, default `C_LOG_2(NUM_CLIENTS)` (min 1): client index width.
- `clk`, in, 1: sole clock.
- `reset`, in, 1: reset, synchronous and active-high.
- `client_req`, in, AMIRequest[NUM_CLIENTS]: client requests (`valid`, `isWrite`, `addr`, `data`, `size`).
- `client_req_grant`, out, 1[NUM_CLIENTS]: request accepted this cycle.
- `client_resp`, out, AMIResponse[NUM_CLIENTS]: routed read responses.
- `client_resp_grant`, in, 1[NUM_CLIENTS]: client consumes its response.
- `mem_req`, out, AMIRequest[AMI_NUM_PORTS]: port 0 reads, port 1 writes.
- `mem_req_grant`, in, 1[AMI_NUM_PORTS]: memory accepts the request.
- `mem_resp`, in, AMIResponse[AMI_NUM_PORTS]: only port 0 carries responses; port 1 is ignored.
- `mem_resp_grant`, out, 1[AMI_NUM_PORTS]: response consumed; port 1 is tied 0.
- `outstanding`, out, `C_LOG_2(MAX_OUTSTANDING)+1`: current read ID FIFO occupancy.
- `proto_err`, out, 1: sticky flag, set when a response arrives with no outstanding read.
- `perf_rd_stall`, `perf_wr_stall`, out, 32: stall-cycle counters (see Configuration).
- `perf_hwm`, out, `C_LOG_2(MAX_OUTSTANDING)+1`: outstanding-read high-water mark (see Configuration).

## Operation
- Transfer rule: a handshake completes when `valid` and `grant` are both high in the same cycle. Writes are posted and produce no response.
- Each port has its own arbiter. Read port candidates are clients with `valid && !isWrite`; write port candidates are clients with `valid && isWrite`.
- Arbiter states:
  - IDLE: pick the first candidate at or after `rr_ptr` (modulo `NUM_CLIENTS`) and drive its request to `mem_req[p]`.
  - LOCKED: entered when the selected request is not granted. The selection is held until that request transfers; no switching happens while `mem_req[p].valid` is high.
  - On transfer: `rr_ptr` ← winner+1 (wraps to 0), state returns to IDLE.
- `client_req_grant[i] = selected_p==i && mem_req_grant[p]`. A client never sees a grant while it is not selected.
- Read issue is masked while `outstanding == MAX_OUTSTANDING`.
  - In IDLE the read port presents no request.
  - A LOCKED read stays valid, because its FIFO slot was checked when it was selected.
  - A same-cycle pop does not unmask issue; masking is based on the registered count.
- On each read transfer, push the winner ID into the FIFO.
- On `mem_resp[0].valid` with the FIFO non-empty:
  - Forward the response to `client_resp[head]`; all other `client_resp` have `valid` = 0.
  - `mem_resp_grant[0] = client_resp_grant[head]`.
  - Pop the FIFO on that handshake.
- Simultaneous push and pop leaves `outstanding` unchanged.
- On `mem_resp[0].valid` with the FIFO empty: set `proto_err`, hold `mem_resp_grant[0]` at 0, forward nothing.
- During `reset`, force all grants and all outgoing `valid` to 0.
  - Next edge: `rr_ptr` = 0, both arbiters IDLE, FIFO empty, `outstanding` = 0, `proto_err` = 0, perf counters = 0.
  - Memory must be reset in the same cycles. Responses to pre-reset reads are not supported and raise `proto_err`.

## Timing
- Request and response paths are combinational: client valid to `mem_req` valid has 0 cycles of latency.
- Arbitration state, `rr_ptr`, FIFO and counters update on the `clk` edge.
- Sustained throughput is 1 read plus 1 write per cycle, up to `MAX_OUTSTANDING` reads in flight.
- The FIFO is a register array with binary read/write pointers of width `C_LOG_2(MAX_OUTSTANDING)`. Pointers wrap naturally.
- Output values while in reset: all `valid` and grants 0, `outstanding` 0, `proto_err` 0.

## Configuration
- Macro `AMI_MUX_PERF_EN`, defined:
  - `perf_rd_stall` increments each cycle `mem_req[0].valid && !mem_req_grant[0]`.
  - `perf_wr_stall` increments each cycle `mem_req[1].valid && !mem_req_grant[1]`.
  - `perf_hwm` tracks the maximum `outstanding` seen.
  - Counters saturate at their maximum and never wrap.
- Macro undefined: all perf outputs are tied to 0 and no counter registers are built.

## Structure
- Shared package `AMIMuxTypes`: client-ID typedef, port index constants `AMI_RD_PORT`=0 and `AMI_WR_PORT`=1, arbiter state enum {IDLE, LOCKED}.
- Sub-module `ami_rr_arbiter` (parameter `N`): request vector in, winner index/valid out, lock and `rr_ptr` internal. Instantiated once per port.
- The ID FIFO is inline.

## Test plan
- Single client, 4 reads to 0x100..0x130 with memory granting immediately → 4 responses on client 0 in order; `outstanding` peaks at 4 and returns to 0.
- 4 clients, all reads valid every cycle, memory always granting → grant sequence 0,1,2,3,0,…; each response reaches the issuing client.
- Client 2 read held with `mem_req_grant[0]`=0 for 5 cycles while client 1 asserts → `mem_req[0]` stays on client 2's address for 5 cycles; client 1 is granted in the cycle after client 2 transfers.
- `MAX_OUTSTANDING`=2, 3 reads issued, no responses → third read never granted; one response consumed → third read granted the next cycle.
- Read and write from different clients in the same cycle → both transfer in that cycle; the write produces no response; `outstanding` increments by 1 only.
- `mem_resp[0].valid` pulsed with FIFO empty → `proto_err`=1 and stays 1 until `reset`; `mem_resp_grant[0]`=0. With `AMI_MUX_PERF_EN` defined, 3 stalled read cycles → `perf_rd_stall`=3.

Source files
------------

// File: rtl/ami_client_mux_pkg.sv
// Shared types for the AMI client mux: request/response structs, port
// indices, arbiter state encoding and a min-1 log2 helper.
package AMIMuxTypes;

    localparam int AMI_ADDR_W    = 64;
    localparam int AMI_DATA_W    = 64;
    localparam int AMI_SIZE_W    = 8;
    localparam int AMI_NUM_PORTS = 2;
    localparam int AMI_RD_PORT   = 0;
    localparam int AMI_WR_PORT   = 1;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                  valid;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIResponse;

    // Widest client index supported; instances use the low CLIENT_ID_W bits.
    typedef logic [7:0] client_id_t;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // log2 rounded up, never below 1 so single-entry indices still have a bit
    function automatic int c_log_2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ami_client_mux_if.sv
// One bundle of N AMI request/response channels. The side that issues
// requests uses the master modport, the side that serves them uses slave.
interface ami_client_mux_if #(parameter int N = 1);
    import AMIMuxTypes::*;

    AMIRequest  [N-1:0] req;
    logic       [N-1:0] req_grant;
    AMIResponse [N-1:0] resp;
    logic       [N-1:0] resp_grant;

    modport master (output req, input req_grant, input resp, output resp_grant);
    modport slave  (input req, output req_grant, output resp, input resp_grant);
endinterface

// File: rtl/ami_client_mux_rr_arbiter.sv
// Round-robin arbiter with a lock: once a selection is presented and not
// granted, it is held until it transfers so the memory side never sees
// the request change under a pending valid.
module ami_rr_arbiter
    import AMIMuxTypes::*;
#(
    parameter int N    = 4,
    parameter int ID_W = c_log_2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            issue_en,   // permits a fresh selection from IDLE
    input  logic            grant,
    output logic [ID_W-1:0] win_idx,
    output logic            win_vld
);
    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] lock_q, lock_d;
    logic [ID_W-1:0] pick, idx;
    logic            pick_vld;

    // first requester at or after rr_ptr; descending loop leaves the nearest
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % N);
            if (issue_en && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // held selection while LOCKED, otherwise the fresh pick
    always_comb begin
        if (state_q == LOCKED) begin
            win_idx = lock_q;
            win_vld = req[lock_q];
        end else begin
            win_idx = pick;
            win_vld = pick_vld;
        end
    end

    // transfer advances rr_ptr past the winner; a refused request locks
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        if (win_vld && grant) begin
            state_d  = IDLE;
            rr_ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + ID_W'(1);
        end else if (win_vld) begin
            state_d = LOCKED;
            lock_d  = win_idx;
        end else begin
            state_d = IDLE;  // a locked client that drops valid frees the port
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
        end
    end

endmodule

// File: rtl/ami_client_mux.sv
// N-client front end for AMI memory: reads go to port 0, writes to port 1,
// each with its own round-robin arbiter. Read responses return in order and
// are routed by an ID FIFO of issuing clients.
// Optional macro AMI_MUX_PERF_EN builds stall counters and a high-water mark.
module ami_client_mux
    import AMIMuxTypes::*;
#(
    parameter int  NUM_CLIENTS     = 4,
    parameter int  MAX_OUTSTANDING = 16,
    parameter int  CLIENT_ID_W     = c_log_2(NUM_CLIENTS),
    localparam int PTR_W           = c_log_2(MAX_OUTSTANDING),
    localparam int OUT_W           = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    ami_client_mux_if.slave  client,
    ami_client_mux_if.master mem,
    output logic [OUT_W-1:0] outstanding,
    output logic             proto_err,
    output logic [31:0]      perf_rd_stall,
    output logic [31:0]      perf_wr_stall,
    output logic [OUT_W-1:0] perf_hwm
);
    logic [NUM_CLIENTS-1:0] rd_cand, wr_cand;
    logic [CLIENT_ID_W-1:0] rd_win, wr_win, head;
    logic                   rd_win_vld, wr_win_vld, rd_req_vld, wr_req_vld;
    logic                   rd_xfer, wr_xfer, resp_ok, resp_xfer;
    logic [CLIENT_ID_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [CLIENT_ID_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OUT_W-1:0]       cnt_q, cnt_d;
    logic                   proto_err_q, proto_err_d;
    AMIResponse             unused_resp1;

    assign unused_resp1 = mem.resp[AMI_WR_PORT];

    // split client requests into read and write candidates
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_cand[i] = client.req[i].valid && !client.req[i].isWrite;
            wr_cand[i] = client.req[i].valid &&  client.req[i].isWrite;
        end
    end

    ami_rr_arbiter #(.N(NUM_CLIENTS), .ID_W(CLIENT_ID_W)) u_rd_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (rd_cand),
        .issue_en (cnt_q != OUT_W'(MAX_OUTSTANDING)),
        .grant    (rd_xfer),
        .win_idx  (rd_win),
        .win_vld  (rd_win_vld)
    );

    ami_rr_arbiter #(.N(NUM_CLIENTS), .ID_W(CLIENT_ID_W)) u_wr_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (wr_cand),
        .issue_en (1'b1),
        .grant    (wr_xfer),
        .win_idx  (wr_win),
        .win_vld  (wr_win_vld)
    );

    // drive each port from its winner and reflect the memory grant back
    always_comb begin
        rd_req_vld = rd_win_vld && !reset;
        wr_req_vld = wr_win_vld && !reset;
        rd_xfer    = rd_req_vld && mem.req_grant[AMI_RD_PORT];
        wr_xfer    = wr_req_vld && mem.req_grant[AMI_WR_PORT];
        mem.req[AMI_RD_PORT]       = client.req[rd_win];
        mem.req[AMI_RD_PORT].valid = rd_req_vld;
        mem.req[AMI_WR_PORT]       = client.req[wr_win];
        mem.req[AMI_WR_PORT].valid = wr_req_vld;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client.req_grant[i] = (rd_xfer && rd_win == CLIENT_ID_W'(i)) ||
                                  (wr_xfer && wr_win == CLIENT_ID_W'(i));
        end
    end

    // route the port-0 response to the client at the FIFO head
    always_comb begin
        head    = fifo_q[rptr_q];
        resp_ok = mem.resp[AMI_RD_PORT].valid && (cnt_q != '0) && !reset;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client.resp[i]       = mem.resp[AMI_RD_PORT];
            client.resp[i].valid = resp_ok && (head == CLIENT_ID_W'(i));
        end
        resp_xfer = resp_ok && client.resp_grant[head];
        mem.resp_grant[AMI_RD_PORT] = resp_xfer;
        mem.resp_grant[AMI_WR_PORT] = 1'b0;
    end

    // ID FIFO push/pop, occupancy and the sticky protocol error
    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (rd_xfer) begin
            fifo_d[wptr_q] = rd_win;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (resp_xfer) rptr_d = rptr_q + PTR_W'(1);
        if (rd_xfer && !resp_xfer) cnt_d = cnt_q + OUT_W'(1);
        if (!rd_xfer && resp_xfer) cnt_d = cnt_q - OUT_W'(1);
        proto_err_d = proto_err_q || (mem.resp[AMI_RD_PORT].valid && cnt_q == '0);
    end

    // FIFO storage needs no reset: entries are only read below the count
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outstanding = reset ? '0 : cnt_q;
    assign proto_err   = proto_err_q && !reset;

`ifdef AMI_MUX_PERF_EN
    logic [31:0]      rd_stall_q, rd_stall_d, wr_stall_q, wr_stall_d;
    logic [OUT_W-1:0] hwm_q, hwm_d;

    // saturating stall counters and occupancy high-water mark
    always_comb begin
        rd_stall_d = rd_stall_q;
        wr_stall_d = wr_stall_q;
        hwm_d      = hwm_q;
        if (rd_req_vld && !mem.req_grant[AMI_RD_PORT] && rd_stall_q != '1)
            rd_stall_d = rd_stall_q + 32'd1;
        if (wr_req_vld && !mem.req_grant[AMI_WR_PORT] && wr_stall_q != '1)
            wr_stall_d = wr_stall_q + 32'd1;
        if (cnt_d > hwm_q) hwm_d = cnt_d;
    end

    // perf registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
            hwm_q      <= '0;
        end else begin
            rd_stall_q <= rd_stall_d;
            wr_stall_q <= wr_stall_d;
            hwm_q      <= hwm_d;
        end
    end

    assign perf_rd_stall = rd_stall_q;
    assign perf_wr_stall = wr_stall_q;
    assign perf_hwm      = hwm_q;
`else
    assign perf_rd_stall = '0;
    assign perf_wr_stall = '0;
    assign perf_hwm      = '0;
`endif

endmodule

// File: tb/tb_ami_client_mux.sv
// Bench for ami_client_mux: reset checks, a table of arbitration vectors,
// hand-written lock / masking / protocol-error sequences, then randomized
// traffic against a queue-based reference model.
module tb_ami_client_mux;
    localparam int NC   = 4;
    localparam int MAXO = 4;
    localparam int OW   = $clog2(MAXO) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [OW-1:0] outstanding, perf_hwm;
    logic          proto_err;
    logic [31:0]   perf_rd_stall, perf_wr_stall;

    ami_client_mux_if #(.N(NC)) cif();
    ami_client_mux_if #(.N(2))  mif();

    ami_client_mux #(.NUM_CLIENTS(NC), .MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .reset         (reset),
        .client        (cif),
        .mem           (mif),
        .outstanding   (outstanding),
        .proto_err     (proto_err),
        .perf_rd_stall (perf_rd_stall),
        .perf_wr_stall (perf_wr_stall),
        .perf_hwm      (perf_hwm)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { bit pend; bit wr; logic [63:0] addr; } creq_t;
    typedef struct { int cid; logic [63:0] addr; } exp_t;
    creq_t       cr [NC];
    exp_t        exp_q [$];
    logic [63:0] mem_q [$];
    int          rr_rd, rr_wr, hold_rd, hold_wr, m_out, m_rds, m_wrs, m_hwm;

    typedef struct {
        logic [NC-1:0] rd, wr;
        logic [1:0]    mg;
        int            rsrc, wsrc;
        logic [NC-1:0] cgnt;
        int            out;
    } vec_t;
    vec_t tbl [7];

    task automatic chk64(string nm, logic [63:0] a, logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, a, e);
        end
    endtask

    task automatic chk1(string nm, logic a, logic e);
        chk64(nm, 64'(a), 64'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] caddr(int i);
        return 64'h1000 + 64'(i) * 64'h10;
    endfunction

    function automatic logic [63:0] rdata(logic [63:0] a);
        return a ^ 64'h5A5A_0000_F00D_0000;
    endfunction

    task automatic drive_client(int i, bit v, bit w, logic [63:0] a);
        cif.req[i].valid   = v;
        cif.req[i].isWrite = w;
        cif.req[i].addr    = a;
        cif.req[i].data    = ~a;
        cif.req[i].size    = 8'd64;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NC; i++) drive_client(i, 1'b0, 1'b0, '0);
        cif.resp_grant = '0;
        mif.req_grant  = '0;
        mif.resp[0]    = '0;
        mif.resp[1]    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        rr_rd = 0; rr_wr = 0; hold_rd = -1; hold_wr = -1;
        m_out = 0; m_rds = 0; m_wrs = 0; m_hwm = 0;
        exp_q.delete();
        mem_q.delete();
        for (int i = 0; i < NC; i++) cr[i].pend = 1'b0;
    endtask

    function automatic logic [NC-1:0] resp_vld_vec();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = cif.resp[i].valid;
        return v;
    endfunction

    task automatic run_random(int ncyc);
        int            srd, swr, hd;
        logic [1:0]    mg;
        logic [NC-1:0] rg, eg, ev;
        bit            rv;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < NC; i++) begin
                if (!cr[i].pend && $urandom_range(0, 2) == 0) begin
                    cr[i].pend = 1'b1;
                    cr[i].wr   = 1'($urandom_range(0, 1));
                    cr[i].addr = {$urandom, $urandom} & ~64'h3F;
                end
                drive_client(i, cr[i].pend, cr[i].wr, cr[i].addr);
            end
            mg = 2'($urandom) | 2'($urandom);
            rg = NC'($urandom) | NC'($urandom);
            rv = (mem_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mif.req_grant      = mg;
            cif.resp_grant     = rg;
            mif.resp[0].valid  = rv;
            mif.resp[0].data   = rv ? rdata(mem_q[0]) : 64'h0;
            mif.resp[0].size   = 8'd64;
            #2;
            // reference selection: held client, else first pending at/after rr
            srd = hold_rd;
            if (srd < 0 && m_out < MAXO)
                for (int k = NC - 1; k >= 0; k--)
                    if (cr[(rr_rd + k) % NC].pend && !cr[(rr_rd + k) % NC].wr) srd = (rr_rd + k) % NC;
            swr = hold_wr;
            if (swr < 0)
                for (int k = NC - 1; k >= 0; k--)
                    if (cr[(rr_wr + k) % NC].pend && cr[(rr_wr + k) % NC].wr) swr = (rr_wr + k) % NC;
            chk1("rnd_rd_vld", mif.req[0].valid, srd >= 0);
            if (srd >= 0) chk64("rnd_rd_addr", mif.req[0].addr, cr[srd].addr);
            chk1("rnd_wr_vld", mif.req[1].valid, swr >= 0);
            if (swr >= 0) begin
                chk64("rnd_wr_addr", mif.req[1].addr, cr[swr].addr);
                chk64("rnd_wr_data", mif.req[1].data, ~cr[swr].addr);
            end
            eg = '0;
            if (srd >= 0 && mg[0]) eg[srd] = 1'b1;
            if (swr >= 0 && mg[1]) eg[swr] = 1'b1;
            chk64("rnd_cgnt", 64'(cif.req_grant), 64'(eg));
            hd = -1;
            if (rv) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd_resp_head: got response, want no reads outstanding");
                end else begin
                    hd = exp_q[0].cid;
                    ev = '0; ev[hd] = 1'b1;
                    chk64("rnd_resp_route", 64'(resp_vld_vec()), 64'(ev));
                    chk64("rnd_resp_data", cif.resp[hd].data, rdata(exp_q[0].addr));
                    chk1("rnd_mresp_gnt", mif.resp_grant[0], rg[hd]);
                end
            end else begin
                chk64("rnd_resp_idle", 64'(resp_vld_vec()), 64'(0));
                chk1("rnd_mresp_gnt0", mif.resp_grant[0], 1'b0);
            end
            chk1("rnd_mresp_gnt1", mif.resp_grant[1], 1'b0);
            // memory side follows what the DUT actually did
            if (mif.req[0].valid && mg[0]) mem_q.push_back(mif.req[0].addr);
            if (rv && mif.resp_grant[0]) void'(mem_q.pop_front());
            // advance model
            if (srd >= 0 && !mg[0]) m_rds++;
            if (swr >= 0 && !mg[1]) m_wrs++;
            if (hd >= 0 && rg[hd]) begin
                void'(exp_q.pop_front());
                m_out--;
            end
            if (srd >= 0) begin
                if (mg[0]) begin
                    exp_q.push_back('{cid: srd, addr: cr[srd].addr});
                    m_out++;
                    rr_rd = (srd + 1) % NC; hold_rd = -1; cr[srd].pend = 1'b0;
                end else hold_rd = srd;
            end
            if (swr >= 0) begin
                if (mg[1]) begin
                    rr_wr = (swr + 1) % NC; hold_wr = -1; cr[swr].pend = 1'b0;
                end else hold_wr = swr;
            end
            if (m_out > m_hwm) m_hwm = m_out;
            tick();
            chk64("rnd_out", 64'(outstanding), 64'(m_out));
            chk1("rnd_perr", proto_err, 1'b0);
        end
    endtask

    initial begin
        int            rc [6];
        bit            rgv [6];
        bit            rdv [6];
        int            ro [6];
        logic [NC-1:0] ev;

        tbl[0] = '{4'b0110, 4'b0000, 2'b01,  1, -1, 4'b0010, 1};
        tbl[1] = '{4'b0110, 4'b1001, 2'b11,  2,  0, 4'b0101, 2};
        tbl[2] = '{4'b0011, 4'b1000, 2'b00,  0,  3, 4'b0000, 2};
        tbl[3] = '{4'b0011, 4'b1000, 2'b10,  0,  3, 4'b1000, 2};
        tbl[4] = '{4'b0011, 4'b0000, 2'b01,  0, -1, 4'b0001, 3};
        tbl[5] = '{4'b0010, 4'b0000, 2'b01,  1, -1, 4'b0010, 4};
        tbl[6] = '{4'b1000, 4'b0000, 2'b01, -1, -1, 4'b0000, 4};
        rc  = '{1, 1, 2, 0, 1, 3};
        rgv = '{0, 1, 1, 1, 1, 1};
        rdv = '{0, 0, 1, 0, 0, 0};
        ro  = '{4, 3, 3, 2, 1, 0};

        // everything quiet while reset is held, even with all inputs active
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < NC; i++) drive_client(i, 1'b1, i[0], caddr(i));
        mif.req_grant     = 2'b11;
        mif.resp[0].valid = 1'b1;
        cif.resp_grant    = '1;
        tick();
        tick();
        #2;
        chk1("rst_rd_vld", mif.req[0].valid, 1'b0);
        chk1("rst_wr_vld", mif.req[1].valid, 1'b0);
        chk64("rst_cgnt", 64'(cif.req_grant), 64'(0));
        chk64("rst_resp", 64'(resp_vld_vec()), 64'(0));
        chk1("rst_mresp_gnt", mif.resp_grant[0], 1'b0);
        chk64("rst_out", 64'(outstanding), 64'(0));
        chk1("rst_perr", proto_err, 1'b0);
        do_reset();

        // arbitration table
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < NC; i++)
                drive_client(i, tbl[v].rd[i] | tbl[v].wr[i], tbl[v].wr[i], caddr(i));
            mif.req_grant = tbl[v].mg;
            #2;
            chk1("tbl_rd_vld", mif.req[0].valid, tbl[v].rsrc >= 0);
            if (tbl[v].rsrc >= 0) chk64("tbl_rd_addr", mif.req[0].addr, caddr(tbl[v].rsrc));
            chk1("tbl_wr_vld", mif.req[1].valid, tbl[v].wsrc >= 0);
            if (tbl[v].wsrc >= 0) chk64("tbl_wr_addr", mif.req[1].addr, caddr(tbl[v].wsrc));
            chk64("tbl_cgnt", 64'(cif.req_grant), 64'(tbl[v].cgnt));
            tick();
            chk64("tbl_out", 64'(outstanding), 64'(tbl[v].out));
        end

        // drain FIFO (order 1,2,0,1); client 3's masked read issues the cycle after a pop
        for (int k = 0; k < 6; k++) begin
            if (k == 3) drive_client(3, 1'b0, 1'b0, '0);
            mif.req_grant     = 2'b01;
            mif.resp[0].valid = 1'b1;
            mif.resp[0].data  = 64'hD000 + 64'(k);
            cif.resp_grant    = rgv[k] ? '1 : '0;
            #2;
            ev = '0; ev[rc[k]] = 1'b1;
            chk64("seq_resp_route", 64'(resp_vld_vec()), 64'(ev));
            chk64("seq_resp_data", cif.resp[rc[k]].data, 64'hD000 + 64'(k));
            chk1("seq_mresp_gnt", mif.resp_grant[0], rgv[k]);
            chk1("seq_rd_vld", mif.req[0].valid, rdv[k]);
            chk64("seq_cgnt", 64'(cif.req_grant), rdv[k] ? 64'h8 : 64'h0);
            tick();
            chk64("seq_out", 64'(outstanding), 64'(ro[k]));
        end
        chk1("seq_perr", proto_err, 1'b0);

        // lock: client 2 refused 5 cycles while client 1 waits
        do_reset();
        drive_client(2, 1'b1, 1'b0, caddr(2));
        for (int c = 0; c < 7; c++) begin
            if (c == 1) drive_client(1, 1'b1, 1'b0, caddr(1));
            if (c == 6) drive_client(2, 1'b0, 1'b0, '0);
            mif.req_grant = (c >= 5) ? 2'b01 : 2'b00;
            #2;
            chk64("lock_addr", mif.req[0].addr, (c < 6) ? caddr(2) : caddr(1));
            chk64("lock_cgnt", 64'(cif.req_grant), (c == 5) ? 64'h4 : ((c == 6) ? 64'h2 : 64'h0));
            tick();
        end

        // three refused read cycles
        do_reset();
        drive_client(0, 1'b1, 1'b0, caddr(0));
        for (int c = 0; c < 4; c++) begin
            mif.req_grant = (c == 3) ? 2'b01 : 2'b00;
            tick();
        end
        drive_client(0, 1'b0, 1'b0, '0);
`ifdef AMI_MUX_PERF_EN
        chk64("perf_rd_stall", 64'(perf_rd_stall), 64'd3);
        chk64("perf_hwm", 64'(perf_hwm), 64'd1);
`else
        chk64("perf_rd_stall", 64'(perf_rd_stall), 64'd0);
        chk64("perf_hwm", 64'(perf_hwm), 64'd0);
`endif
        chk64("perf_wr_stall", 64'(perf_wr_stall), 64'd0);

        // response with nothing outstanding
        do_reset();
        cif.resp_grant    = '1;
        mif.resp[0].valid = 1'b1;
        #2;
        chk1("perr_mresp_gnt", mif.resp_grant[0], 1'b0);
        chk64("perr_resp", 64'(resp_vld_vec()), 64'(0));
        tick();
        mif.resp[0].valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk1("perr_sticky", proto_err, 1'b1);
            tick();
        end
        do_reset();
        chk1("perr_cleared", proto_err, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        run_random(2500);
`ifdef AMI_MUX_PERF_EN
        chk64("rnd_perf_rd", 64'(perf_rd_stall), 64'(m_rds));
        chk64("rnd_perf_wr", 64'(perf_wr_stall), 64'(m_wrs));
        chk64("rnd_perf_hwm", 64'(perf_hwm), 64'(m_hwm));
`else
        chk64("rnd_perf_rd", 64'(perf_rd_stall), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
